// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: memory op codes, access sizes and FSM states.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  // Anything that is not a byte or halfword op is treated as a word access.
  function automatic mem_size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering, byte enables, load extraction/extension and
// misalignment detection for the MEM stage.
module mem_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic        misaligned_c,
  output logic [31:0] wdata_c,
  output logic [3:0]  byte_en_c,
  output logic [31:0] load_data_c
);

  mem_size_e   size;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    size    = op_size(op);
    rd_half = addr_lo[1] ? read_data[31:16] : read_data[15:0];
    case (addr_lo)
      2'd0:    rd_byte = read_data[7:0];
      2'd1:    rd_byte = read_data[15:8];
      2'd2:    rd_byte = read_data[23:16];
      default: rd_byte = read_data[31:24];
    endcase

    misaligned_c = (mem_read || mem_write) &&
                   (((size == SZ_WORD) && (addr_lo != 2'b00)) ||
                    ((size == SZ_HALF) && addr_lo[0]));

    // Stores replicate the datum across lanes; reads always fetch the whole word.
    wdata_c   = store_data;
    byte_en_c = 4'b1111;
    if (mem_write) begin
      case (size)
        SZ_BYTE: begin
          wdata_c   = {4{store_data[7:0]}};
          byte_en_c = 4'(4'b0001 << addr_lo);
        end
        SZ_HALF: begin
          wdata_c   = {2{store_data[15:0]}};
          byte_en_c = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_c   = store_data;
          byte_en_c = 4'b1111;
        end
      endcase
    end

    case (op)
      OP_LB:   load_data_c = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data_c = {24'd0, rd_byte};
      OP_LH:   load_data_c = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data_c = {16'd0, rd_half};
      default: load_data_c = read_data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ready handshake, WB register and MEM->EXE bypass.
// Optional performance counters are enabled with `define MEM_PERF_CNT_EN.
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
`ifdef MEM_PERF_CNT_EN
  ,
  parameter int unsigned STALL_CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       Instr1_IN,
  input  logic [31:0]       Instr1_PC_IN,
  input  logic [31:0]       ALU_result1_IN,
  input  logic [4:0]        WriteRegister1_IN,
  input  logic [31:0]       MemWriteData1_IN,
  input  logic              RegWrite1_IN,
  input  logic [5:0]        ALU_Control1_IN,
  input  logic              MemRead1_IN,
  input  logic              MemWrite1_IN,
  output logic              DMem_Req,
  output logic              DMem_Write,
  output logic [ADDR_W-1:0] DMem_Addr,
  output logic [31:0]       DMem_WData,
  output logic [3:0]        DMem_ByteEn,
  input  logic              DMem_Ready,
  input  logic [31:0]       DMem_RData,
  output logic [31:0]       Instr1_OUT,
  output logic [31:0]       Instr1_PC_OUT,
  output logic [31:0]       WriteData1_OUT,
  output logic [4:0]        WriteRegister1_OUT,
  output logic              RegWrite1_OUT,
  output logic              AlignFault1_OUT,
  output logic [4:0]        BypassReg1_MEMEXE,
  output logic [31:0]       BypassData1_MEMEXE,
  output logic              BypassValid1_MEMEXE,
`ifdef MEM_PERF_CNT_EN
  output logic [STALL_CNT_W-1:0] PerfLoads,
  output logic [STALL_CNT_W-1:0] PerfStores,
  output logic [STALL_CNT_W-1:0] PerfStallCycles,
`endif
  output logic              Stall_fmem
);

  mem_state_e  state, state_nxt;
  logic        misaligned;
  logic        mem_op;
  logic [31:0] load_data;

  mem_align u_align (
    .op           (ALU_Control1_IN),
    .addr_lo      (ALU_result1_IN[1:0]),
    .mem_read     (MemRead1_IN),
    .mem_write    (MemWrite1_IN),
    .store_data   (MemWriteData1_IN),
    .read_data    (DMem_RData),
    .misaligned_c (misaligned),
    .wdata_c      (DMem_WData),
    .byte_en_c    (DMem_ByteEn),
    .load_data_c  (load_data)
  );

  // Request and address follow the frozen EXE inputs, so they stay stable while BUSY.
  assign mem_op     = (MemRead1_IN || MemWrite1_IN) && !misaligned;
  assign DMem_Req   = RESET && mem_op;
  assign DMem_Write = MemWrite1_IN;
  assign DMem_Addr  = {ALU_result1_IN[ADDR_W-1:2], 2'b00};
  assign Stall_fmem = RESET && mem_op && !DMem_Ready;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_op && !DMem_Ready) state_nxt = BUSY;
      BUSY: if (DMem_Ready)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // WB register; a stalled cycle loads a bubble with the debug fields still tracking.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      WriteData1_OUT     <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
      AlignFault1_OUT    <= 1'b0;
    end else begin
      Instr1_OUT         <= Instr1_IN;
      Instr1_PC_OUT      <= Instr1_PC_IN;
      WriteRegister1_OUT <= WriteRegister1_IN;
      if (Stall_fmem) begin
        WriteData1_OUT  <= ALU_result1_IN;
        RegWrite1_OUT   <= 1'b0;
        AlignFault1_OUT <= 1'b0;
      end else begin
        WriteData1_OUT  <= (MemRead1_IN && !misaligned) ? load_data : ALU_result1_IN;
        RegWrite1_OUT   <= RegWrite1_IN && !MemWrite1_IN && !misaligned;
        AlignFault1_OUT <= misaligned;
      end
    end
  end

  assign BypassReg1_MEMEXE   = WriteRegister1_OUT;
  assign BypassData1_MEMEXE  = WriteData1_OUT;
  assign BypassValid1_MEMEXE = RegWrite1_OUT && (WriteRegister1_OUT != 5'd0);

`ifdef MEM_PERF_CNT_EN
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic done;
  assign done = mem_op && DMem_Ready;

  // Saturating counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PerfLoads       <= '0;
      PerfStores      <= '0;
      PerfStallCycles <= '0;
    end else begin
      if (done && MemRead1_IN && (PerfLoads != CNT_MAX))
        PerfLoads <= PerfLoads + STALL_CNT_W'(1);
      if (done && MemWrite1_IN && (PerfStores != CNT_MAX))
        PerfStores <= PerfStores + STALL_CNT_W'(1);
      if (Stall_fmem && (PerfStallCycles != CNT_MAX))
        PerfStallCycles <= PerfStallCycles + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of EXE and upstream of WB.
- Takes EXE's registered results and performs loads/stores through a req/ready data-memory handshake.
- Handles byte/halfword extraction, sign- and zero-extension, and store byte-lane steering.
- Produces the WB register, the MEM->EXE bypass triple, and Stall_fmem back to EXE.

Parameters:
- ADDR_W, 32, data-memory address width.
- STALL_CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- Instr1_IN  in  32  instruction (debug).
- Instr1_PC_IN  in  32  PC (debug).
- ALU_result1_IN  in  32  ALU result; serves as the effective address for memory ops.
- WriteRegister1_IN  in  5  destination register.
- MemWriteData1_IN  in  32  store data, already forwarded by EXE.
- RegWrite1_IN  in  1  register write enable.
- ALU_Control1_IN  in  6  op code; selects the memory access size and sign.
- MemRead1_IN  in  1  load.
- MemWrite1_IN  in  1  store.
- DMem_Req  out  1  access request.
- DMem_Write  out  1  1 = store.
- DMem_Addr  out  ADDR_W  word-aligned address (addr[1:0] = 0).
- DMem_WData  out  32  lane-steered store data.
- DMem_ByteEn  out  4  byte enables.
- DMem_Ready  in  1  access complete; DMem_RData valid in the same cycle.
- DMem_RData  in  32  read word.
- Instr1_OUT  out  32  to WB (debug).
- Instr1_PC_OUT  out  32  to WB (debug).
- WriteData1_OUT  out  32  value written back.
- WriteRegister1_OUT  out  5  WB destination register.
- RegWrite1_OUT  out  1  WB write enable.
- AlignFault1_OUT  out  1  misaligned access retired this slot.
- BypassReg1_MEMEXE  out  5  equals WriteRegister1_OUT.
- BypassData1_MEMEXE  out  32  equals WriteData1_OUT.
- BypassValid1_MEMEXE  out  1  RegWrite1_OUT && WriteRegister1_OUT != 0.
- Stall_fmem  out  1  freezes EXE and upstream stages.

Behaviour:
- Reset: all registered outputs 0; FSM returns to IDLE; DMem_Req = 0 combinationally while RESET = 0. Reset mid-access abandons the access; no writeback occurs.
- mem_op = (MemRead1_IN || MemWrite1_IN) && !misaligned.
- misaligned: word op with addr[1:0] != 0, or half op with addr[0] = 1.
- FSM has two states, IDLE and BUSY.
  - IDLE: if mem_op, drive DMem_Req = 1 combinationally. If DMem_Ready = 1 in the same cycle, the access completes with zero stall. Otherwise go to BUSY.
  - BUSY: hold DMem_Req and all DMem_* outputs stable. Inputs are also stable, because EXE is frozen. On DMem_Ready = 1, return to IDLE.
- Stall_fmem = mem_op && !DMem_Ready (combinational).
- While Stall_fmem = 1, the output register loads a bubble: RegWrite1_OUT = 0, AlignFault1_OUT = 0; the debug fields still load.
- Output register update (posedge, when not stalled):
  - Loads: WriteData1_OUT is the extracted, extended DMem_RData.
  - Non-memory ops: WriteData1_OUT = ALU_result1_IN.
  - Stores: WriteData1_OUT = ALU_result1_IN and RegWrite1_OUT = 0.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; little-endian, lane 0 = bits 7:0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB replicates the byte to all lanes; ByteEn = 1 << addr[1:0].
  - SH replicates the halfword; ByteEn = addr[1] ? 4'b1100 : 4'b0011.
  - SW uses ByteEn = 4'b1111.
- Reads always present ByteEn = 4'b1111.
- Misaligned op: no request is issued, no stall, RegWrite1_OUT = 0, AlignFault1_OUT = 1 for one slot.
- Latency is one cycle plus the memory wait cycles.
- Back-to-back memory ops are allowed: the next request may issue in the cycle after completion.

Optional Feature:
- Macro MEM_PERF_CNT_EN.
- With it:
  - adds outputs PerfLoads, PerfStores and PerfStallCycles, each STALL_CNT_W bits.
  - Loads and stores increment on completion; stall cycles increment on each cycle with Stall_fmem = 1.
  - All counters saturate at all-ones and reset to 0.
- Without it: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the 6-bit memory op codes: OP_LB=6'h20, OP_LH=6'h21, OP_LW=6'h23, OP_LBU=6'h24, OP_LHU=6'h25, OP_SB=6'h28, OP_SH=6'h29, OP_SW=6'h2B;
  - the FSM state typedef (IDLE, BUSY).
- One natural sub-module: mem_align, a combinational block for lane steering, byte enables, load extraction/extension and misalignment detection.

Test Plan:
- ALU op, RegWrite = 1, reg 5, result 0x1234 -> next cycle WriteData1_OUT = 0x1234, BypassValid = 1, BypassReg = 5, Stall_fmem = 0 throughout.
- LW at 0x100 with DMem_Ready delayed 3 cycles, RData = 0xDEADBEEF:
  - Stall_fmem is high for exactly 3 cycles, with Req/Addr stable throughout;
  - RegWrite1_OUT = 0 during the stall;
  - then WriteData1_OUT = 0xDEADBEEF.
- LB at 0x103 with RData = 0x80FFFFFF -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 with RData = 0x8000_1234 -> 0x00008000.
- SB at 0x201 with data 0x000000AB -> WData = 0xABABABAB, ByteEn = 4'b0010, Write = 1, RegWrite1_OUT = 0.
- LW at 0x102 -> no Req, AlignFault1_OUT = 1, RegWrite1_OUT = 0; write to reg 0 -> BypassValid = 0.
- Assert RESET low while in BUSY -> Req drops immediately, all outputs 0, FSM is IDLE after release.
